// File: rtl/led_pkg.sv
// Shared types and the 7-segment glyph table for the LED digit array.
//   seg7_t    : active-high segment vector {G,F,E,D,C,B,A}
//   SEG_OFF   : all segments dark
//   SEG_CODE  : glyphs for nibble values 0..F (A,b,C,d,E,F for 10..15)
//   seg7_of() : nibble + hex_mode -> glyph; BCD mode blanks values above 9
package led_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'b0000000;

    localparam seg7_t SEG_CODE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic seg7_t seg7_of(input logic [3:0] nibble, input logic hex_mode);
        if (!hex_mode && (nibble > 4'd9)) begin
            return SEG_OFF;
        end
        return SEG_CODE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> 7-segment glyph decoder (active-high).
//   i_nibble   : value to show
//   i_hex_mode : 1 = show A..F, 0 = BCD (values above 9 decode to dark)
//   o_seg      : {G,F,E,D,C,B,A}, 1 = lit
module seg7_decode
    import led_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output seg7_t      o_seg
);

    assign o_seg = seg7_of(i_nibble, i_hex_mode);

endmodule

// File: rtl/led_scan_mux.sv
// Multiplexed common-anode 7-segment display driver.
//   Clk, Rst_n        : clock, synchronous active-low reset
//   wr_en/wr_data/
//   wr_dp/wr_blank    : one-cycle write of digit values, decimal points and blank mask;
//                       applied at the next frame boundary
//   hex_mode, lz_en   : live decode mode and leading-zero suppression
//   seg, seg_dp, dig  : registered segment, decimal point and digit-enable drives
//   frame_start       : pulse when the digit 0 slot begins
//   busy              : a write is pending and not yet displayed
module led_scan_mux
    import led_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SLOT_CYCLES    = 12500,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic [DIGITS-1:0]     wr_blank,
    input  logic                  hex_mode,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_start,
    output logic                  busy
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_pend_data, r_disp_data;
    logic [DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic [DIGITS-1:0]   r_pend_blank, r_disp_blank;
    logic                r_pend_valid;
    logic [6:0]          r_seg;
    logic                r_seg_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_frame_start;

    logic              w_wrap, w_boundary, w_lit;
    logic [3:0]        w_nib;
    logic              w_sel_dp, w_sel_blank, w_sel_lz;
    logic [DIGITS-1:0] w_onehot, w_lz;
    seg7_t             w_dec_seg, w_seg_hi;
    logic              w_dp_hi;
    logic [DIGITS-1:0] w_dig_hi;

    assign w_wrap     = (r_cnt == LAST_CNT);
    assign w_boundary = w_wrap && (r_idx == LAST_IDX);
    assign w_lit      = (r_cnt >= BLANK_CNT);

    // Digit i is a leading zero when it and every digit above it hold 0; digit 0 never is.
    always_comb begin
        logic v_zero;
        v_zero = 1'b1;
        w_lz   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_zero  = v_zero && (r_disp_data[4*i +: 4] == 4'h0);
            w_lz[i] = v_zero && (i != 0);
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_lz    = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_disp_data[4*i +: 4];
                w_sel_dp    = r_disp_dp[i];
                w_sel_blank = r_disp_blank[i];
                w_sel_lz    = lz_en && w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_seg7_decode (
        .i_nibble   (w_nib),
        .i_hex_mode (hex_mode),
        .o_seg      (w_dec_seg)
    );

    // Forced blank kills the dp as well; BCD-invalid (decoder) and LZ blanking keep it.
    always_comb begin
        w_seg_hi = SEG_OFF;
        w_dp_hi  = 1'b0;
        w_dig_hi = '0;
        if (w_lit) begin
            w_dig_hi = w_onehot;
            if (!w_sel_blank) begin
                w_seg_hi = w_sel_lz ? SEG_OFF : w_dec_seg;
                w_dp_hi  = w_sel_dp;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_valid  <= 1'b0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
            r_disp_blank  <= '0;
            r_seg         <= SEG_OFF ^ {7{SEG_INV}};
            r_seg_dp      <= SEG_INV;
            r_dig         <= {DIGITS{DIG_INV}};
            r_frame_start <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Only a valid pending write reaches the display, so a boundary-cycle bypass
            // is never overwritten by stale pending data.
            if (wr_en && w_boundary) begin
                r_disp_data  <= wr_data;
                r_disp_dp    <= wr_dp;
                r_disp_blank <= wr_blank;
                r_pend_valid <= 1'b0;
            end else if (wr_en) begin
                r_pend_data  <= wr_data;
                r_pend_dp    <= wr_dp;
                r_pend_blank <= wr_blank;
                r_pend_valid <= 1'b1;
            end else if (w_boundary && r_pend_valid) begin
                r_disp_data  <= r_pend_data;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end

            r_seg         <= w_seg_hi ^ {7{SEG_INV}};
            r_seg_dp      <= w_dp_hi ^ SEG_INV;
            r_dig         <= w_dig_hi ^ {DIGITS{DIG_INV}};
            r_frame_start <= w_boundary;
        end
    end

    assign seg         = r_seg;
    assign seg_dp      = r_seg_dp;
    assign dig         = r_dig;
    assign frame_start = r_frame_start;
    assign busy        = r_pend_valid;

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux: the stimulus process predicts every cycle's outputs
// from a time-based model and queues them; a monitor compares after each clock edge.
module tb_led_scan_mux;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  wr_blank = '0;
    logic        hex_mode = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  dig;
    logic        frame_start;
    logic        busy;

    led_scan_mux #(
        .DIGITS         (DIGITS),
        .SLOT_CYCLES    (SLOT),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .hex_mode    (hex_mode),
        .lz_en       (lz_en),
        .seg         (seg),
        .seg_dp      (seg_dp),
        .dig         (dig),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    // Expected {seg, seg_dp, dig, frame_start, busy} after each edge.
    logic [13:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset, shown and pending contents.
    int          m_t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_dp = '0, m_bl = '0, m_pdp = '0, m_pbl = '0;
    logic        m_pv = 1'b0;
    logic        g_hex = 1'b0, g_lz = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Active-high {segments, dp} for digit idx of the shown value.
    function automatic logic [7:0] model_digit(input int idx);
        int         msnz;
        logic [3:0] v;
        logic       dark;
        msnz = -1;
        for (int i = 0; i < DIGITS; i++) begin
            if (m_disp[i*4 +: 4] != 4'h0) msnz = i;
        end
        v = m_disp[idx*4 +: 4];
        if (m_bl[idx]) return 8'h00;
        dark = (!g_hex && v > 4'd9) || (g_lz && idx != 0 && idx > msnz);
        return {dark ? 7'h00 : seg_tab[v], m_dp[idx]};
    endfunction

    function automatic logic next_is_boundary();
        return (m_t % SLOT == SLOT - 1) && ((m_t / SLOT) % DIGITS == DIGITS - 1);
    endfunction

    task automatic step(input logic rst_n, input logic en, input logic [15:0] data,
                        input logic [3:0] dp, input logic [3:0] bl);
        logic [13:0] e;
        logic [7:0]  dd;
        int          cnt, idx;
        logic        bnd;
        @(negedge Clk);
        Rst_n    = rst_n;
        wr_en    = en;
        wr_data  = data;
        wr_dp    = dp;
        wr_blank = bl;
        hex_mode = g_hex;
        lz_en    = g_lz;
        if (!rst_n) begin
            e      = {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0};
            m_t    = 0;
            m_disp = '0; m_dp = '0; m_bl = '0;
            m_pend = '0; m_pdp = '0; m_pbl = '0;
            m_pv   = 1'b0;
        end else begin
            cnt = m_t % SLOT;
            idx = (m_t / SLOT) % DIGITS;
            bnd = (cnt == SLOT - 1) && (idx == DIGITS - 1);
            if (cnt < BLANK) begin
                e[13:6] = {7'h7F, 1'b1};
                e[5:2]  = 4'hF;
            end else begin
                dd      = model_digit(idx);
                e[13:6] = ~dd;
                e[5:2]  = ~(4'b0001 << idx);
            end
            e[1] = bnd;
            if (en && bnd) begin
                m_disp = data; m_dp = dp; m_bl = bl; m_pv = 1'b0;
            end else if (en) begin
                m_pend = data; m_pdp = dp; m_pbl = bl; m_pv = 1'b1;
            end else if (bnd && m_pv) begin
                m_disp = m_pend; m_dp = m_pdp; m_bl = m_pbl; m_pv = 1'b0;
            end
            e[0] = m_pv;
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Monitor: one comparison per clock edge that has a queued prediction.
    initial begin
        logic [13:0] e, a;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {seg, seg_dp, dig, frame_start, busy};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scan_out t=%0t got seg=%h dp=%b dig=%h fs=%b busy=%b, want seg=%h dp=%b dig=%h fs=%b busy=%b",
                             $time, a[13:7], a[6], a[5:2], a[1], a[0],
                             e[13:7], e[6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int          guard;
        logic [15:0] mask;
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        // Reset held for 3 cycles, then first frame.
        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        g_hex = 1'b1;
        step(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        idle(80);

        // Mid-frame write, then two writes in one frame.
        idle(5);
        step(1'b1, 1'b1, 16'h5678, 4'h0, 4'h0);
        idle(70);
        step(1'b1, 1'b1, 16'hABCD, 4'h3, 4'h0);
        idle(3);
        step(1'b1, 1'b1, 16'h2468, 4'h0, 4'h0);
        idle(70);

        // Write landing exactly on the frame boundary.
        guard = 0;
        while (!next_is_boundary() && guard < 64) begin
            idle(1);
            guard++;
        end
        step(1'b1, 1'b1, 16'h4321, 4'h8, 4'h0);
        idle(70);

        // Hex/BCD and leading-zero suppression.
        g_lz = 1'b1;
        step(1'b1, 1'b1, 16'h00AF, 4'h0, 4'h0);
        idle(70);
        g_hex = 1'b0;
        idle(40);
        step(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
        idle(70);

        // Decimal point and forced blank.
        g_lz = 1'b0;
        step(1'b1, 1'b1, 16'h9999, 4'b0100, 4'b0001);
        idle(70);

        // Reset mid-slot while digit 2 is lit.
        guard = 0;
        while (!((m_t % SLOT == 4) && ((m_t / SLOT) % DIGITS == 2)) && guard < 64) begin
            idle(1);
            guard++;
        end
        step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(40);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) g_hex = 1'($urandom);
            if ($urandom_range(0, 99) == 0) g_lz = 1'($urandom);
            mask = masks[$urandom_range(0, 4)];
            step(($urandom_range(0, 599) != 0), ($urandom_range(0, 15) == 0),
                 16'($urandom) & mask, 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge Clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain got %0d pending predictions, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
